// File: rtl/lbt_allocator_pkg.sv
// Shared label-table definitions: LBTYPE_* codes, allocator state encodings and the region-fit helper.
// The helper honours LBT_ALLOC_ALIGN4_EN (bases rounded up to a multiple of 4 when defined).
package lbt_allocator_pkg;

    localparam logic [5:0] LBTYPE_UNDEFINED = 6'd0;
    localparam logic [5:0] LBTYPE_CODE      = 6'd1;
    localparam logic [5:0] LBTYPE_DATA      = 6'd2;
    localparam logic [5:0] LBTYPE_STACK     = 6'd3;
    localparam logic [5:0] LBTYPE_HEAP      = 6'd4;

    typedef enum logic [1:0] {
        LBA_IDLE  = 2'd0,
        LBA_ALLOC = 2'd1,
        LBA_RESP  = 2'd2,
        LBA_CLEAR = 2'd3
    } lba_state_e;

    typedef struct packed {
        logic [15:0] base;
        logic [16:0] lim;
        logic        err;
    } lba_fit_t;

    // Carve count words from the free pointer; lim becomes the new free pointer on success.
    function automatic lba_fit_t lba_fit(input logic [16:0] free_ptr,
                                         input logic [15:0] count,
                                         input logic [17:0] mem_words);
        lba_fit_t    f;
        logic [16:0] b;
        logic [17:0] e;
`ifdef LBT_ALLOC_ALIGN4_EN
        b = (free_ptr + 17'd3) & ~17'd3;
`else
        b = free_ptr;
`endif
        e      = {1'b0, b} + {2'b00, count};
        f.base = b[15:0];
        f.lim  = e[16:0];
        f.err  = (count == 16'd0) || (e > mem_words);
        return f;
    endfunction

endpackage

// File: rtl/lbt_allocator.sv
// Label-table allocator: bump-pointer label allocation and full table clear over the MMU write port.
// Build option LBT_ALLOC_ALIGN4_EN aligns every allocated base to 4 words.
module lbt_allocator
    import lbt_allocator_pkg::*;
#(
    parameter int MEM_WORDS  = 65536,
    parameter int NUM_LABELS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [11:0] req_lbid,
    input  logic [5:0]  req_type,
    input  logic [15:0] req_count,
    output logic        resp_valid,
    output logic [15:0] resp_base,
    output logic        resp_err,
    input  logic        clr_start,
    output logic        clr_done,
    output logic        busy,
    output logic [16:0] free_ptr,
    output logic [11:0] lbidw,
    output logic [5:0]  lbTypew,
    output logic [15:0] basew,
    output logic [15:0] countw,
    output logic        we
);

    localparam logic [17:0] MEM_LIM   = 18'(MEM_WORDS);
    localparam logic [11:0] LAST_LBID = 12'(NUM_LABELS - 1);

    lba_state_e state;
    lba_fit_t   fit;
    lba_fit_t   fit_q;

    // Fit is evaluated on the accept edge so the table write lands in the ALLOC cycle.
    always_comb fit = lba_fit(free_ptr, req_count, MEM_LIM);

    assign req_ready = (state == LBA_IDLE) && !clr_start && !reset;
    assign busy      = (state != LBA_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LBA_IDLE;
            fit_q      <= '0;
            free_ptr   <= '0;
            we         <= 1'b0;
            lbidw      <= '0;
            lbTypew    <= '0;
            basew      <= '0;
            countw     <= '0;
            resp_valid <= 1'b0;
            resp_base  <= '0;
            resp_err   <= 1'b0;
            clr_done   <= 1'b0;
        end else begin
            we         <= 1'b0;
            resp_valid <= 1'b0;
            resp_base  <= '0;
            resp_err   <= 1'b0;
            clr_done   <= 1'b0;
            case (state)
                LBA_IDLE: begin
                    if (clr_start) begin
                        state   <= LBA_CLEAR;
                        we      <= 1'b1;
                        lbidw   <= '0;
                        lbTypew <= LBTYPE_UNDEFINED;
                        basew   <= '0;
                        countw  <= '0;
                    end else if (req_valid) begin
                        state <= LBA_ALLOC;
                        fit_q <= fit;
                        if (!fit.err) begin
                            we      <= 1'b1;
                            lbidw   <= req_lbid;
                            lbTypew <= req_type;
                            basew   <= fit.base;
                            countw  <= req_count;
                        end
                    end
                end
                LBA_ALLOC: begin
                    state      <= LBA_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= fit_q.err;
                    if (!fit_q.err) begin
                        free_ptr  <= fit_q.lim;
                        resp_base <= fit_q.base;
                    end
                end
                LBA_RESP: state <= LBA_IDLE;
                LBA_CLEAR: begin
                    // lbidw holds the entry being written this cycle; stop once the last one is out.
                    if (lbidw == LAST_LBID) begin
                        state    <= LBA_IDLE;
                        free_ptr <= '0;
                        clr_done <= 1'b1;
                    end else begin
                        we    <= 1'b1;
                        lbidw <= lbidw + 12'd1;
                    end
                end
                default: state <= LBA_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lbt_allocator.sv
// Bench for lbt_allocator: per-cycle event map built from the allocation rules, checked every negedge.
`timescale 1ns/1ps
module tb_lbt_allocator;
    import lbt_allocator_pkg::*;

    localparam int MEMW = 64;
    localparam int NL   = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [11:0] req_lbid = '0;
    logic [5:0]  req_type = '0;
    logic [15:0] req_count = '0;
    logic        resp_valid;
    logic [15:0] resp_base;
    logic        resp_err;
    logic        clr_start = 1'b0;
    logic        clr_done;
    logic        busy;
    logic [16:0] free_ptr;
    logic [11:0] lbidw;
    logic [5:0]  lbTypew;
    logic [15:0] basew;
    logic [15:0] countw;
    logic        we;

    lbt_allocator #(.MEM_WORDS(MEMW), .NUM_LABELS(NL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_lbid(req_lbid), .req_type(req_type), .req_count(req_count),
        .resp_valid(resp_valid), .resp_base(resp_base), .resp_err(resp_err),
        .clr_start(clr_start), .clr_done(clr_done), .busy(busy), .free_ptr(free_ptr),
        .lbidw(lbidw), .lbTypew(lbTypew), .basew(basew), .countw(countw), .we(we)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit we;  int lbid; int typ; int base; int cnt;
        bit rv;  int rbase; bit rerr; bit cdone; bit busy;
    } ev_t;

    ev_t exp_q[int];
    int  fp_chg[int];
    int  checks = 0;
    int  errors = 0;
    int  we_cnt = 0;
    int  model_fp = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, expv);
        end
    endtask

    function automatic ev_t get_ev(input int c);
        ev_t z;
        z = '{default: 0};
        if (exp_q.exists(c)) z = exp_q[c];
        return z;
    endfunction

    function automatic int model_base(input int fp);
`ifdef LBT_ALLOC_ALIGN4_EN
        return ((fp + 3) / 4) * 4;
`else
        return fp;
`endif
    endfunction

    // Compare process: every negedge the DUT must match the event map.
    initial begin : cmp
        ev_t e;
        int  cur_fp;
        cur_fp = 0;
        forever begin
            @(negedge clk);
            if (fp_chg.exists(cyc)) cur_fp = fp_chg[cyc];
            e = get_ev(cyc);
            chk("we", 32'(we), 32'(e.we));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("req_ready", 32'(req_ready), 32'(!e.busy && !clr_start && !reset));
            chk("resp_valid", 32'(resp_valid), 32'(e.rv));
            chk("clr_done", 32'(clr_done), 32'(e.cdone));
            chk("free_ptr", 32'(free_ptr), 32'(cur_fp));
            if (e.we) begin
                chk("lbidw", 32'(lbidw), 32'(e.lbid));
                chk("lbTypew", 32'(lbTypew), 32'(e.typ));
                chk("basew", 32'(basew), 32'(e.base));
                chk("countw", 32'(countw), 32'(e.cnt));
            end
            if (e.rv) begin
                chk("resp_base", 32'(resp_base), 32'(e.rbase));
                chk("resp_err", 32'(resp_err), 32'(e.rerr));
            end
            if (we === 1'b1) we_cnt++;
        end
    end

    // Call right after a posedge (+1ns) with the DUT idle.
    task automatic do_alloc(input int lbid, input int typ, input int cnt,
                            output int got_base, output bit got_err);
        int  p, b, e;
        bit  err;
        ev_t v;
        p   = cyc;
        b   = model_base(model_fp);
        e   = b + cnt;
        err = (cnt == 0) || (e > MEMW);
        req_valid = 1'b1; req_lbid = 12'(lbid); req_type = 6'(typ); req_count = 16'(cnt);
        v = get_ev(p + 1);
        v.busy = 1;
        if (!err) begin
            v.we = 1; v.lbid = lbid; v.typ = typ; v.base = b; v.cnt = cnt;
        end
        exp_q[p + 1] = v;
        v = get_ev(p + 2);
        v.busy = 1; v.rv = 1; v.rbase = err ? 0 : b; v.rerr = err;
        exp_q[p + 2] = v;
        if (!err) begin
            model_fp = e;
            fp_chg[p + 2] = e;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        got_base = int'(resp_base);
        got_err  = resp_err;
        @(posedge clk); #1;
    endtask

    task automatic clear_start(input bit with_req);
        int  p;
        ev_t v;
        p = cyc;
        clr_start = 1'b1;
        req_valid = with_req; req_lbid = 12'd7; req_type = LBTYPE_DATA; req_count = 16'd4;
        for (int k = 0; k < NL; k++) begin
            v = get_ev(p + 1 + k);
            v.busy = 1; v.we = 1; v.lbid = k; v.typ = int'(LBTYPE_UNDEFINED); v.base = 0; v.cnt = 0;
            exp_q[p + 1 + k] = v;
        end
        v = get_ev(p + NL + 1);
        v.cdone = 1;
        exp_q[p + NL + 1] = v;
        fp_chg[p + NL + 1] = 0;
        model_fp = 0;
        we_cnt = 0;
        #3;
        chk("ready_during_clr_start", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        clr_start = 1'b0;
        req_valid = 1'b0;
    endtask

    initial begin : drv
        int b0, b1;
        bit e0, e1;
        bit found;
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_free_ptr", 32'(free_ptr), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        do_alloc(0, int'(LBTYPE_CODE), 32, b0, e0);
        chk("a0_base", 32'(b0), 32'd0);
        chk("a0_err", 32'(e0), 32'd0);
        chk("a0_fp", 32'(free_ptr), 32'd32);
        do_alloc(1, int'(LBTYPE_DATA), 16, b0, e0);
        chk("a1_base", 32'(b0), 32'd32);
        chk("a1_fp", 32'(free_ptr), 32'd48);

        do_alloc(2, int'(LBTYPE_DATA), 0, b0, e0);
        chk("zero_err", 32'(e0), 32'd1);
        chk("zero_base", 32'(b0), 32'd0);
        chk("zero_fp", 32'(free_ptr), 32'd48);

        do_alloc(3, int'(LBTYPE_STACK), 16, b0, e0);
        chk("fit_base", 32'(b0), 32'd48);
        chk("fit_err", 32'(e0), 32'd0);
        chk("fit_fp", 32'(free_ptr), 32'd64);
        do_alloc(4, int'(LBTYPE_HEAP), 1, b0, e0);
        chk("over_err", 32'(e0), 32'd1);
        chk("over_fp", 32'(free_ptr), 32'd64);

        clear_start(1'b1);
        repeat (NL) @(posedge clk);
        #1;
        chk("clr_we_pulses", 32'(we_cnt), 32'(NL));
        chk("clr_done_pulse", 32'(clr_done), 32'd1);
        chk("clr_fp", 32'(free_ptr), 32'd0);
        chk("clr_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        do_alloc(5, int'(LBTYPE_CODE), 5, b0, e0);
        do_alloc(6, int'(LBTYPE_DATA), 4, b1, e1);
        chk("seq_base0", 32'(b0), 32'd0);
`ifdef LBT_ALLOC_ALIGN4_EN
        chk("seq_base1", 32'(b1), 32'd8);
        chk("seq_fp", 32'(free_ptr), 32'd12);
`else
        chk("seq_base1", 32'(b1), 32'd5);
        chk("seq_fp", 32'(free_ptr), 32'd9);
`endif

        clear_start(1'b0);
        found = 1'b0;
        for (int i = 0; i < NL + 4; i++) begin
            if (we === 1'b1 && lbidw == 12'd100) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("abort_reached_100", 32'(found), 32'd1);
        reset = 1'b1;
        exp_q.delete();
        fp_chg.delete();
        fp_chg[cyc] = 0;
        model_fp = 0;
        #1;
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_lbidw", 32'(lbidw), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_fp", 32'(free_ptr), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (NL - 90) @(posedge clk);
        #1;

        do_alloc(0, int'(LBTYPE_CODE), 8, b0, e0);
        chk("post_rst_base", 32'(b0), 32'd0);
        do_alloc(0, int'(LBTYPE_DATA), 4, b1, e1);
        chk("redef_base", 32'(b1), 32'd8);
        chk("redef_fp", 32'(free_ptr), 32'd12);

        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
